fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word address into IMEM. IMEM read is combinational and same-cycle.
- Captures the returned instruction word, with its PC, into a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake. Supports redirects (branch/jump) with flush, and a sticky fetch fault.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- IMEM_BYTES, 1024: IMEM size in bytes. A PC >= IMEM_BYTES is out of range.
- QDEPTH, 2: instruction FIFO depth in entries. Must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_addr  out  32  byte address to IMEM; always equals the current PC.
- imem_data  in  32  instruction word from IMEM, valid in the same cycle.
- redirect_valid  in  1  load a new PC and flush the FIFO.
- redirect_pc  in  32  target PC when redirect_valid=1.
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at the FIFO head.
- out_pc  out  32  PC of the instruction at the FIFO head.
- fault  out  1  sticky fetch fault.

Behaviour:
- Reset, sampled at a rising edge with rst=1:
  - pc<=RESET_PC, count<=0, FIFO pointers<=0, fault<=0.
  - Outputs afterwards: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
  - Reset mid-operation discards all FIFO contents and any pending redirect.
- Combinational signals:
  - imem_addr=pc.
  - out_valid=(count!=0).
  - pop=out_valid & out_ready.
  - range_ok=(pc < IMEM_BYTES).
  - space=(count<QDEPTH) | pop.
  - push=space & range_ok & !fault & !redirect_valid.
- Edge update, priority order (rst > redirect > normal):
  - Redirect, when redirect_valid=1:
    - FIFO flushed (count<=0, pointers reset).
    - pc<=redirect_pc; no push.
    - A pop in the same cycle completes for decode but is irrelevant because the FIFO is flushed.
    - If redirect_pc[1:0]!=0, fault<=1 and pc still loads.
    - A redirect clears nothing else, and does not clear an existing fault.
  - Normal, when redirect_valid=0:
    - If push: write {pc, imem_data} at the tail, then pc<=pc+4.
    - If pop: advance the head.
    - count<=count+push-pop; simultaneous push and pop at full is legal.
  - Out-of-range PC:
    - If range_ok=0 and there is no redirect: no push and pc holds.
    - fault<=1, set on the edge after the out-of-range PC is first presented.
- Fault is sticky until reset.
  - With fault=1, no further pushes occur.
  - Entries already in the FIFO still drain normally.
- FIFO outputs are taken from the head entry register; no combinational path exists from imem_data to out_instr.
- Latency:
  - An instruction fetched in cycle N is visible at out_* in cycle N+1.
  - After reset release, out_valid first rises 1 cycle after the first non-reset edge.
- Throughput: one instruction per cycle while out_ready=1.
- Backpressure: with out_ready=0, the FIFO fills to QDEPTH and pc freezes. The held out_instr/out_pc stay stable while out_valid=1 and out_ready=0.
- PC width is 32-bit; pc+4 wraps modulo 2^32. This is unreachable in practice because range_ok fails first for any IMEM_BYTES <= 2^32-4.
- Pointers wrap modulo QDEPTH.
  - A non-power-of-two QDEPTH is handled by explicit compare-and-clear.
  - count is $clog2(QDEPTH+1) bits wide.

Test Plan:
- Reset with IMEM words 0..3 = 0x11,0x22,0x33,0x44, then hold out_ready=1 -> out_valid rises 1 cycle after reset release; out_pc/out_instr sequence (0,0x11),(4,0x22),(8,0x33),(12,0x44) on consecutive cycles.
- Hold out_ready=0 for 5 cycles after reset, then raise it -> count saturates at 2; imem_addr holds at 8; out_pc=0 stable throughout the stall; the release drains PCs 0,4,8 with no gap or duplicate.
- Redirect to 0x40 while the FIFO holds PCs 0,4 -> next cycle out_valid=0; following cycle out_pc=0x40 with instr=mem[16]; PCs 0 and 4 are never delivered after the redirect.
- Redirect to 0x42 -> fault=1 the next cycle; out_valid stays 0 with no further pushes; fault remains 1 after a later redirect to 0x0, until rst.
- Redirect to 0x3FC and run with out_ready=1 -> the instruction at 0x3FC is delivered; pc=0x400 then sets fault the next cycle; imem_addr stays 0x400; the queue drains and out_valid drops.
- Assert rst for 1 cycle while the FIFO is full and redirect_valid=1 -> afterwards out_valid=0, fault=0, imem_addr=RESET_PC; the normal sequence resumes from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads IMEM combinationally and queues {pc, instr}
// pairs for decode, with redirect/flush and a sticky fetch fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(QDEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(QDEPTH);

  logic [31:0]     pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [31:0]     epc_q   [QDEPTH];
  logic [31:0]     einstr_q[QDEPTH];

  logic pop, push, space, range_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    // Compare-and-clear so non-power-of-two depths wrap correctly.
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign range_ok  = (pc_q < IMEM_BYTES);
  assign space     = (count_q < FullCnt) | pop;
  assign push      = space & range_ok & ~fault_q & ~redirect_valid;
  assign fault     = fault_q;

  // Head data comes only from registered entries; zeroed while the queue is empty.
  assign out_instr = out_valid ? einstr_q[head_q] : '0;
  assign out_pc    = out_valid ? epc_q[head_q]    : '0;

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
    end else begin
      if (push) begin
        pc_d   = pc_q + 32'd4;
        tail_d = ptr_inc(tail_q);
      end
      if (pop) head_d = ptr_inc(head_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (!range_ok) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      epc_q[tail_q]    <= pc_q;
      einstr_q[tail_q] <= imem_data;
    end
  end

endmodule
